// File: rtl/minhash_topk_sorter_if.sv
// Hasher-side and extender-side ready/valid bundle for the bottom-K MinHash sorter.
// The sorter takes the slave modport; whoever feeds and drains it takes master.
interface minhash_topk_sorter_if #(
    parameter int SIG_W = 32,
    parameter int IDX_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [SIG_W-1:0] in_sig;
    logic [IDX_W-1:0] in_idx;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] out_sig;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_sig, in_idx, in_last, out_ready,
        input  in_ready, out_valid, out_sig, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_sig, in_idx, in_last, out_ready,
        output in_ready, out_valid, out_sig, out_idx, out_last
    );
endinterface

// File: rtl/minhash_topk_sorter.sv
// Streaming bottom-K sorter: keeps the TOP_K smallest signatures of a fragment in a
// sorted register array and drains them smallest-first once the fragment's last item lands.
module minhash_topk_sorter #(
    parameter int SIG_W = 32,
    parameter int IDX_W = 5,
    parameter int TOP_K = 4,
    parameter int DEDUP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    minhash_topk_sorter_if.slave   bus,
    output logic                   busy
);

    typedef enum logic {ST_COLLECT, ST_DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [TOP_K-1:0] r_vld;
    logic [TOP_K-1:0] w_vld_next;
    logic [SIG_W-1:0] r_sig      [TOP_K];
    logic [SIG_W-1:0] w_sig_next [TOP_K];
    logic [IDX_W-1:0] r_idx      [TOP_K];
    logic [IDX_W-1:0] w_idx_next [TOP_K];

    // Per-slot compare results plus the neighbouring slot contents used by the shifts.
    logic [TOP_K-1:0] w_gt;
    logic [TOP_K-1:0] w_eq;
    logic [TOP_K-1:0] w_dn_gt;
    logic [TOP_K-1:0] w_dn_vld;
    logic [SIG_W-1:0] w_dn_sig [TOP_K];
    logic [IDX_W-1:0] w_dn_idx [TOP_K];
    logic [TOP_K-1:0] w_up_vld;
    logic [SIG_W-1:0] w_up_sig [TOP_K];
    logic [IDX_W-1:0] w_up_idx [TOP_K];

    logic w_accept;
    logic w_dup;
    logic w_insert;
    logic w_pop;
    logic w_out_valid;
    logic w_out_last;

    // Invalid slots count as +infinity, so w_gt is a thermometer code whose lowest set
    // bit is the insert position; strict '>' places a new item after any equal entries.
    genvar gi;
    generate
        for (gi = 0; gi < TOP_K; gi++) begin : g_slot
            assign w_gt[gi] = !r_vld[gi] || (r_sig[gi] > bus.in_sig);
            assign w_eq[gi] = r_vld[gi] && (r_sig[gi] == bus.in_sig);

            if (gi == 0) begin : g_bottom
                assign w_dn_gt[gi]  = 1'b0;
                assign w_dn_vld[gi] = 1'b0;
                assign w_dn_sig[gi] = '0;
                assign w_dn_idx[gi] = '0;
            end else begin : g_below
                assign w_dn_gt[gi]  = w_gt[gi-1];
                assign w_dn_vld[gi] = r_vld[gi-1];
                assign w_dn_sig[gi] = r_sig[gi-1];
                assign w_dn_idx[gi] = r_idx[gi-1];
            end

            if (gi == TOP_K-1) begin : g_top
                assign w_up_vld[gi] = 1'b0;
                assign w_up_sig[gi] = '0;
                assign w_up_idx[gi] = '0;
            end else begin : g_above
                assign w_up_vld[gi] = r_vld[gi+1];
                assign w_up_sig[gi] = r_sig[gi+1];
                assign w_up_idx[gi] = r_idx[gi+1];
            end
        end

        if (TOP_K == 1) begin : g_last_single
            assign w_out_last = w_out_valid;
        end else begin : g_last_multi
            assign w_out_last = w_out_valid && !r_vld[1];
        end
    endgenerate

    assign bus.in_ready  = (r_state == ST_COLLECT) && !clear;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_dup         = (DEDUP != 0) && (|w_eq);
    assign w_insert      = w_accept && !w_dup;

    assign w_out_valid   = (r_state == ST_DRAIN) && r_vld[0];
    assign w_pop         = w_out_valid && bus.out_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.out_sig   = w_out_valid ? r_sig[0] : '0;
    assign bus.out_idx   = w_out_valid ? r_idx[0] : '0;

    assign busy = (|r_vld) || (r_state == ST_DRAIN);

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: if (w_accept && bus.in_last) w_state_next = ST_DRAIN;
                ST_DRAIN:   if (w_pop && w_out_last)     w_state_next = ST_COLLECT;
                default:    w_state_next = ST_COLLECT;
            endcase
        end
    end

    // Insert and pop never coincide: input is only accepted in COLLECT, output only leaves in DRAIN.
    always_comb begin
        for (int i = 0; i < TOP_K; i++) begin
            w_vld_next[i] = r_vld[i];
            w_sig_next[i] = r_sig[i];
            w_idx_next[i] = r_idx[i];
            if (clear) begin
                w_vld_next[i] = 1'b0;
            end else if (w_insert) begin
                if (w_dn_gt[i]) begin
                    w_vld_next[i] = w_dn_vld[i];
                    w_sig_next[i] = w_dn_sig[i];
                    w_idx_next[i] = w_dn_idx[i];
                end else if (w_gt[i]) begin
                    w_vld_next[i] = 1'b1;
                    w_sig_next[i] = bus.in_sig;
                    w_idx_next[i] = bus.in_idx;
                end
            end else if (w_pop) begin
                w_vld_next[i] = w_up_vld[i];
                w_sig_next[i] = w_up_sig[i];
                w_idx_next[i] = w_up_idx[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
            r_vld   <= '0;
        end else begin
            r_state <= w_state_next;
            r_vld   <= w_vld_next;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        r_sig <= w_sig_next;
        r_idx <= w_idx_next;
    end

endmodule
